// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the I/S/B/J/U fields of an RV32 instruction word.
// Two-stage valid/ready pipeline with representability flags and saturating counters.
module imm_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err_range,
    output logic             out_err_sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] ImmSelI = 3'd0;
    localparam logic [2:0] ImmSelS = 3'd1;
    localparam logic [2:0] ImmSelB = 3'd2;
    localparam logic [2:0] ImmSelJ = 3'd3;
    localparam logic [2:0] ImmSelU = 3'd4;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_base_q, s1_base_d;
    logic [31:0]      s1_fields_q, s1_fields_d;
    logic [2:0]       s1_sel_q, s1_sel_d;
    logic             s1_err_range_q, s1_err_range_d;
    logic             s1_err_sel_q, s1_err_sel_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_inst_q, s2_inst_d;
    logic             s2_err_range_q, s2_err_range_d;
    logic             s2_err_sel_q, s2_err_sel_d;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        adv1, adv2, out_hs;
    logic        sext_ok11, sext_ok12, sext_ok20;
    logic [31:0] enc_fields;
    logic        enc_err_range, enc_err_sel;
    logic [31:0] field_mask;
    logic [31:0] merged_inst;

    assign adv2     = !s2_valid_q | out_ready;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = adv1;
    assign out_hs   = s2_valid_q & out_ready;

    // Upper bits must be a pure sign extension of the highest encodable bit.
    assign sext_ok11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign sext_ok12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign sext_ok20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        enc_fields    = '0;
        enc_err_range = 1'b0;
        enc_err_sel   = 1'b0;
        case (in_sel)
            ImmSelI: begin
                enc_fields    = {in_imm[11:0], 20'b0};
                enc_err_range = !sext_ok11;
            end
            ImmSelS: begin
                enc_fields    = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                enc_err_range = !sext_ok11;
            end
            ImmSelB: begin
                enc_fields    = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
                enc_err_range = !sext_ok12 | in_imm[0];
            end
            ImmSelJ: begin
                enc_fields    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
                enc_err_range = !sext_ok20 | in_imm[0];
            end
            ImmSelU: begin
                enc_fields    = {in_imm[31:12], 12'b0};
                enc_err_range = |in_imm[11:0];
            end
            default: enc_err_sel = 1'b1;
        endcase
    end

    // Undefined formats get an empty mask so the base word passes through untouched.
    always_comb begin
        field_mask = 32'h0000_0000;
        case (s1_sel_q)
            ImmSelI:          field_mask = 32'hFFF0_0000;
            ImmSelS, ImmSelB: field_mask = 32'hFE00_0F80;
            ImmSelJ, ImmSelU: field_mask = 32'hFFFF_F000;
            default:          field_mask = 32'h0000_0000;
        endcase
        merged_inst = (s1_base_q & ~field_mask) | (s1_fields_q & field_mask);
    end

    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_base_d      = s1_base_q;
        s1_fields_d    = s1_fields_q;
        s1_sel_d       = s1_sel_q;
        s1_err_range_d = s1_err_range_q;
        s1_err_sel_d   = s1_err_sel_q;
        s2_valid_d     = s2_valid_q;
        s2_inst_d      = s2_inst_q;
        s2_err_range_d = s2_err_range_q;
        s2_err_sel_d   = s2_err_sel_q;
        enc_cnt_d      = enc_cnt_q;
        err_cnt_d      = err_cnt_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_base_d      = in_base;
                s1_fields_d    = enc_fields;
                s1_sel_d       = in_sel;
                s1_err_range_d = enc_err_range;
                s1_err_sel_d   = enc_err_sel;
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_d      = merged_inst;
                s2_err_range_d = s1_err_range_q;
                s2_err_sel_d   = s1_err_sel_q;
            end
        end

        if (cnt_clr) begin
            enc_cnt_d = '0;
            err_cnt_d = '0;
        end else if (out_hs) begin
            if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + CNT_W'(1);
            if ((s2_err_range_q | s2_err_sel_q) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_base_q      <= '0;
            s1_fields_q    <= '0;
            s1_sel_q       <= '0;
            s1_err_range_q <= 1'b0;
            s1_err_sel_q   <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_inst_q      <= '0;
            s2_err_range_q <= 1'b0;
            s2_err_sel_q   <= 1'b0;
            enc_cnt_q      <= '0;
            err_cnt_q      <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_base_q      <= s1_base_d;
            s1_fields_q    <= s1_fields_d;
            s1_sel_q       <= s1_sel_d;
            s1_err_range_q <= s1_err_range_d;
            s1_err_sel_q   <= s1_err_sel_d;
            s2_valid_q     <= s2_valid_d;
            s2_inst_q      <= s2_inst_d;
            s2_err_range_q <= s2_err_range_d;
            s2_err_sel_q   <= s2_err_sel_d;
            enc_cnt_q      <= enc_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_inst      = s2_inst_q;
    assign out_err_range = s2_err_range_q;
    assign out_err_sel   = s2_err_sel_q;
    assign enc_cnt       = enc_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: vector table plus directed pipeline sequences, scoreboard
// checking and a random round-trip run against a reference immediate decoder.
module tb_imm_encoder;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [31:0]      in_base, in_imm;
    logic [2:0]       in_sel;
    logic             out_valid, out_ready;
    logic [31:0]      out_inst;
    logic             out_err_range, out_err_sel;
    logic             cnt_clr;
    logic [CNT_W-1:0] enc_cnt, err_cnt;

    // Narrow-counter instance used only to reach saturation quickly.
    logic             sat_valid, sat_in_ready, sat_out_valid, sat_rng, sat_sel, sat_clr;
    logic [31:0]      sat_inst;
    logic [2:0]       sat_enc, sat_err;

    always #5 clk = ~clk;

    imm_encoder #(.CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_imm(in_imm), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_err_range(out_err_range),
        .out_err_sel(out_err_sel), .cnt_clr(cnt_clr), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    imm_encoder #(.CNT_W(3)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(sat_valid), .in_ready(sat_in_ready),
        .in_base(32'h0000_0013), .in_imm(32'h0000_1000), .in_sel(3'd0),
        .out_valid(sat_out_valid), .out_ready(1'b1), .out_inst(sat_inst),
        .out_err_range(sat_rng), .out_err_sel(sat_sel), .cnt_clr(sat_clr),
        .enc_cnt(sat_enc), .err_cnt(sat_err)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        rng;
        logic        sel_err;
    } vec_t;

    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   err_pops = 0;
    bit   rnd_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] sel, input logic [31:0] base,
                                input logic [31:0] imm, input logic [31:0] inst,
                                input logic rng, input logic sel_err);
        vec_t v;
        v.sel = sel; v.base = base; v.imm = imm; v.inst = inst; v.rng = rng; v.sel_err = sel_err;
        return v;
    endfunction

    // Reference encoder written from the field table, range checked arithmetically.
    function automatic vec_t model(input logic [2:0] sel, input logic [31:0] base,
                                   input logic [31:0] imm);
        vec_t v;
        logic signed [31:0] s;
        s = imm;
        v = mk(sel, base, imm, base, 1'b0, 1'b0);
        case (sel)
            3'd0: begin
                v.inst[31:20] = imm[11:0];
                v.rng = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                v.inst[31:25] = imm[11:5];
                v.inst[11:7]  = imm[4:0];
                v.rng = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                v.inst[31]    = imm[12];
                v.inst[7]     = imm[11];
                v.inst[30:25] = imm[10:5];
                v.inst[11:8]  = imm[4:1];
                v.rng = (s < -4096) || (s > 4095) || imm[0];
            end
            3'd3: begin
                v.inst[31]    = imm[20];
                v.inst[19:12] = imm[19:12];
                v.inst[20]    = imm[11];
                v.inst[30:21] = imm[10:1];
                v.rng = (s < -1048576) || (s > 1048575) || imm[0];
            end
            3'd4: begin
                v.inst[31:12] = imm[31:12];
                v.rng = (imm[11:0] != 12'd0);
            end
            default: v.sel_err = 1'b1;
        endcase
        return v;
    endfunction

    // Core immediate generator.
    function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'b0};
        endcase
    endfunction

    always @(negedge clk) begin
        vec_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", out_inst);
            end else begin
                e = sb_q.pop_front();
                check("out_inst", out_inst, e.inst);
                check("out_err_range", {31'b0, out_err_range}, {31'b0, e.rng});
                check("out_err_sel", {31'b0, out_err_sel}, {31'b0, e.sel_err});
                if (!e.rng && !e.sel_err) check("round_trip", decode(out_inst, e.sel), e.imm);
                pops++;
                if (e.rng || e.sel_err) err_pops++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_sel   = v.sel;
        in_base  = v.base;
        in_imm   = v.imm;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        vec_t v;
        logic [CNT_W-1:0] enc0, err0;
        int p0, e0;

        vt[0] = mk(3'd0, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0, 1'b0);
        vt[1] = mk(3'd2, 32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0, 1'b0);
        vt[2] = mk(3'd2, 32'h0000_0063, 32'h0000_1000, 32'h8000_0063, 1'b1, 1'b0);
        vt[3] = mk(3'd3, 32'h0000_006F, 32'h0000_0001, 32'h0000_006F, 1'b1, 1'b0);
        vt[4] = mk(3'd4, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0, 1'b0);
        vt[5] = mk(3'd1, 32'h0000_2023, 32'hFFFF_FFFC, 32'hFE00_2E23, 1'b0, 1'b0);
        vt[6] = mk(3'd1, 32'h0000_2023, 32'h0000_0800, 32'h8000_2023, 1'b1, 1'b0);
        vt[7] = mk(3'd3, 32'h0000_006F, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0, 1'b0);
        vt[8] = mk(3'd4, 32'h0000_0017, 32'h0000_0800, 32'h0000_0017, 1'b1, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; in_base = '0; in_imm = '0; in_sel = '0;
        out_ready = 1'b1; cnt_clr = 1'b0; sat_valid = 1'b0; sat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_flags", {30'b0, out_err_range, out_err_sel}, 32'd0);
        check("rst_counters", {enc_cnt, err_cnt}, 32'd0);
        @(posedge clk);
        #1;

        // Latency: presented in cycle 0, accepted at the end of it, valid in cycle 2.
        send(vt[0]);
        check("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
        drain();
        check("lat_enc_cnt", {16'b0, enc_cnt}, 32'd1);

        for (int k = 1; k < 9; k++) begin
            enc0 = enc_cnt;
            err0 = err_cnt;
            send(vt[k]);
            drain();
            check("vec_enc_cnt", {16'b0, enc_cnt}, {16'b0, enc0} + 32'd1);
            check("vec_err_cnt", {16'b0, err_cnt},
                  {16'b0, err0} + ((vt[k].rng || vt[k].sel_err) ? 32'd1 : 32'd0));
        end

        // Undefined format, counter clear coinciding with its handshake.
        send(mk(3'd7, 32'hDEAD_BEEF, 32'h0000_0123, 32'hDEAD_BEEF, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        check("sel7_valid", {31'b0, out_valid}, 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_enc_cnt", {16'b0, enc_cnt}, 32'd0);
        check("clr_err_cnt", {16'b0, err_cnt}, 32'd0);
        drain();

        // Backpressure: two buffered, third waits, then three back-to-back results.
        out_ready = 1'b0;
        send(vt[0]);
        send(vt[1]);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        fork
            send(vt[4]);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
                    check("bp_hold_inst", out_inst, vt[0].inst);
                    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_drain_valid", {31'b0, out_valid}, 32'd1);
                end
            end
        join
        drain();
        check("bp_enc_cnt", {16'b0, enc_cnt}, 32'd3);
        check("bp_err_cnt", {16'b0, err_cnt}, 32'd0);

        // Asynchronous reset with two results buffered.
        out_ready = 1'b0;
        send(vt[5]);
        send(vt[7]);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_enc_cnt", {16'b0, enc_cnt}, 32'd0);
        check("mid_rst_err_cnt", {16'b0, err_cnt}, 32'd0);
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);
        send(vt[4]);
        drain();
        check("post_rst_enc_cnt", {16'b0, enc_cnt}, 32'd1);

        // Saturation on the 3-bit counter instance.
        sat_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        sat_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_enc_cnt", {29'b0, sat_enc}, 32'd7);
        check("sat_err_cnt", {29'b0, sat_err}, 32'd7);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("sat_clr", {26'b0, sat_enc, sat_err}, 32'd0);

        // Random run with random output stalls.
        pulse_clr();
        p0 = pops;
        e0 = err_pops;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [2:0]  s;
                    logic [31:0] imm;
                    int unsigned r;
                    r = $urandom_range(9);
                    s = (r < 8) ? 3'(r % 5) : 3'(5 + $urandom_range(2));
                    case ($urandom_range(3))
                        0:       imm = $urandom;
                        1:       imm = {{20{1'b0}}, 12'($urandom)} - 32'd2048;
                        2:       imm = {{11{1'b0}}, 21'($urandom)} - 32'd1048576;
                        default: imm = $urandom & 32'hFFFF_F000;
                    endcase
                    if ($urandom_range(1) == 0) imm[0] = 1'b0;
                    v = model(s, $urandom, imm);
                    send(v);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rnd_count", pops - p0, 32'd10000);
        check("rnd_enc_cnt", {16'b0, enc_cnt}, pops - p0);
        check("rnd_err_cnt", {16'b0, err_cnt}, err_pops - e0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
